// File: rtl/mem_pkg.sv
// Shared types and funct3 encodings for the
// MEM-stage data-memory access unit.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/data_mem_access_if.sv
// Data-memory req/ack bus between the MEM stage
// (master) and a variable-latency memory (slave).
interface data_mem_access_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/half of a read word
// and sign- or zero-extends it per funct3.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  f3,
  output logic [31:0] data
);

  logic [31:0] sh;
  logic [7:0]  b;
  logic [15:0] h;

  assign sh = rdata >> {off, 3'b000};
  assign b  = sh[7:0];
  assign h  = off[1] ? rdata[31:16] : rdata[15:0];

  // extend the selected lane to 32 bits
  always_comb begin
    data = rdata;
    unique case (f3)
      LB:      data = {{24{b[7]}}, b};
      LH:      data = {{16{h[15]}}, h};
      LBU:     data = {24'h0, b};
      LHU:     data = {16'h0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_access.sv
// MEM-stage initiator: req/ack data-memory access
// with pipeline stall, load formatting and timeout.
module data_mem_access
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead_in,
  input  logic        memWrite_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] rs2_in,
  input  logic [31:0] inst_in,
  output logic        stall_out,
  output logic [31:0] loadData_out,
  output logic        loadValid_out,
  output logic        misaligned_out,
  output logic        busErr_out,
  data_mem_access_if.master dmem
);

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic        rd;
  logic        wr;
  logic        ok_f3;
  logic        aligned;
  logic        go;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ld;
  logic        unused_inst;

  assign f3  = inst_in[14:12];
  assign off = ALUResult_in[1:0];
  assign rd  = memRead_in;
  assign wr  = memWrite_in;

  assign unused_inst = ^{inst_in[31:15], inst_in[11:0]};

  // legality, alignment and store lane generation
  always_comb begin
    ok_f3 = 1'b0;
    if (rd & ~wr)
      ok_f3 = f3 inside {LB, LH, LW, LBU, LHU};
    else if (wr & ~rd)
      ok_f3 = f3 inside {SB, SH, SW};
    aligned = 1'b1;
    be      = 4'b1111;
    wdata   = rs2_in;
    case (f3[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{rs2_in[7:0]}};
      end
      2'b01: begin
        aligned = ~off[0];
        be      = 4'b0011 << off;
        wdata   = {2{rs2_in[15:0]}};
      end
      default: aligned = (off == 2'b00);
    endcase
    go = ok_f3 & aligned;
  end

  assign stall_out = (state == REQ) |
                     ((state == IDLE) & go);

  load_align u_align (
    .rdata (dmem.dmem_rdata),
    .off   (off_q),
    .f3    (f3_q),
    .data  (ld)
  );

  // access FSM with registered bus and pulse outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      f3_q            <= '0;
      off_q           <= '0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dmem.dmem_be    <= '0;
      loadData_out    <= '0;
      loadValid_out   <= 1'b0;
      misaligned_out  <= 1'b0;
      busErr_out      <= 1'b0;
    end else begin
      loadValid_out  <= 1'b0;
      misaligned_out <= 1'b0;
      busErr_out     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            state           <= REQ;
            cnt             <= '0;
            f3_q            <= f3;
            off_q           <= off;
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= wr;
            dmem.dmem_addr  <= {ALUResult_in[31:2], 2'b00};
            dmem.dmem_wdata <= wdata;
            dmem.dmem_be    <= be;
          end else if (rd | wr) begin
            misaligned_out <= 1'b1;
          end
        end
        REQ: begin
          if (dmem.dmem_ack) begin
            state         <= DONE;
            dmem.dmem_req <= 1'b0;
            if (!dmem.dmem_we) begin
              loadData_out  <= ld;
              loadValid_out <= 1'b1;
            end
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            state         <= DONE;
            dmem.dmem_req <= 1'b0;
            busErr_out    <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
